sr_flag_bank_ctrl: RTL and testbench

Shared controller for a bank of SR-style status flags written by several independent requesters. Each requester issues set/reset mask commands through a req/ack handshake. A round-robin arbiter serialises the commands onto the flag bank, and an optional lock lets one requester run a multi-command burst without interleaving. The block sits between control-plane agents (FSMs, CPU shim) and any logic that consumes the flags `q`/`qbar`.

---
 rtl/sr_flag_bank_ctrl_pkg.sv | 37 +++
 rtl/sr_flag_bank_ctrl_if.sv | 37 +++
 rtl/sr_flag_bank_ctrl_rr_arbiter.sv | 39 +++
 rtl/sr_flag_bank_ctrl.sv | 152 +++++++++++++++
 tb/tb_sr_flag_bank_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_flag_bank_ctrl_pkg.sv
// sr_flag_pkg: shared types, command codes and the per-bit flag update
// function for the sr_flag_bank_ctrl block.
//   state_t  : controller FSM states (ST_IDLE, ST_LOCKED)
//   CMD_*    : {S,R} command encodings for one flag bit
//   sr_next  : next value of one flag bit for a given {S,R} pair
// Optional feature macro: SR_FLAG_ILLEGAL_CHECK_EN. When it is undefined,
// the {S,R}=11 code toggles the bit. When it is defined, the caller
// suppresses the whole command, and 11 simply holds here.
package sr_flag_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_CLR  = 2'b01;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_ILL  = 2'b11;

    function automatic logic sr_next(input logic q, input logic s, input logic r);
        logic nq;
        case ({s, r})
            CMD_HOLD: nq = q;
            CMD_CLR:  nq = 1'b0;
            CMD_SET:  nq = 1'b1;
`ifdef SR_FLAG_ILLEGAL_CHECK_EN
            CMD_ILL:  nq = q;
`else
            CMD_ILL:  nq = ~q;
`endif
            default:  nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_flag_bank_ctrl_if.sv
// sr_flag_bank_ctrl_if: requester-side bus of the flag bank controller.
//   req/lock    : per-requester request valid and keep-ownership bits
//   set_mask    : per-requester S bits, requester i at [i*NFLAG +: NFLAG]
//   rst_mask    : per-requester R bits, same packing
//   ack         : one-cycle pulse per requester when its command is applied
//   q/qbar      : flag state and its complement
//   owner/locked: current lock owner and lock status
//   err         : sticky illegal-command flag
// Modports: master (requesters/testbench), slave (controller).
interface sr_flag_bank_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*NFLAG-1:0] set_mask;
    logic [NREQ*NFLAG-1:0] rst_mask;
    logic [NREQ-1:0]       ack;
    logic [NFLAG-1:0]      q;
    logic [NFLAG-1:0]      qbar;
    logic [IW-1:0]         owner;
    logic                  locked;
    logic                  err;

    modport master (
        output req, lock, set_mask, rst_mask,
        input  ack, q, qbar, owner, locked, err
    );

    modport slave (
        input  req, lock, set_mask, rst_mask,
        output ack, q, qbar, owner, locked, err
    );

endinterface

// File: rtl/sr_flag_bank_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   elig      : eligible requesters
//   ptr       : highest-priority index for this cycle
//   gnt       : one-hot grant
//   gnt_idx   : encoded index of the granted requester
//   gnt_valid : a grant was issued
module rr_arbiter
    import sr_flag_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_valid
);

    // Scan from ptr upward with wrap-around; the first eligible index wins.
    always_comb begin
        logic [IW-1:0] idx_s;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx_s     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s = IW'((int'(ptr) + i) % NREQ);
            if (!gnt_valid && elig[idx_s]) begin
                gnt_valid  = 1'b1;
                gnt_idx    = idx_s;
                gnt[idx_s] = 1'b1;
            end else begin
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/sr_flag_bank_ctrl.sv
// sr_flag_bank_ctrl: arbitrated controller for a bank of SR status flags.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : sr_flag_bank_ctrl_if.slave (req/lock/masks in; ack/q/qbar/owner/locked/err out)
// Optional feature macro: SR_FLAG_ILLEGAL_CHECK_EN. When it is defined, a
// command with any {S,R}=11 bit is acked but changes no flag and sets the
// sticky err. When it is undefined, 11 toggles the bit and err stays 0.
module sr_flag_bank_ctrl
    import sr_flag_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8
) (
    input  logic                clk,
    input  logic                rst,
    sr_flag_bank_ctrl_if.slave  bus
);

    localparam int IW = $clog2(NREQ);

    state_t            state_r, state_next_s;
    logic [NREQ-1:0]   ack_r, elig_s, own_mask_s, gnt_s;
    logic [IW-1:0]     ptr_r, ptr_next_s, owner_r, owner_next_s, gnt_idx_s;
    logic              gnt_valid_s;
    logic [NFLAG-1:0]  q_r, qbar_r, q_next_s, sel_set_s, sel_rst_s;
    logic              err_r, err_next_s;

    // Eligibility: a requester acked this cycle is still presenting its old
    // command, so it sits out one cycle; while locked, only the owner competes.
    always_comb begin
        own_mask_s          = '0;
        own_mask_s[owner_r] = 1'b1;
        if (state_r == ST_LOCKED) begin
            elig_s = bus.req & ~ack_r & own_mask_s;
        end else begin
            elig_s = bus.req & ~ack_r;
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .elig      (elig_s),
        .ptr       (ptr_r),
        .gnt       (gnt_s),
        .gnt_idx   (gnt_idx_s),
        .gnt_valid (gnt_valid_s)
    );

    // FSM next state, lock owner and round-robin pointer.
    always_comb begin
        state_next_s = state_r;
        owner_next_s = owner_r;
        ptr_next_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    if (gnt_idx_s == IW'(NREQ - 1)) begin
                        ptr_next_s = '0;
                    end else begin
                        ptr_next_s = gnt_idx_s + IW'(1);
                    end
                    if (bus.lock[gnt_idx_s]) begin
                        state_next_s = ST_LOCKED;
                        owner_next_s = gnt_idx_s;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (gnt_valid_s) begin
                    if (bus.lock[gnt_idx_s]) begin
                        state_next_s = ST_LOCKED;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else if (!bus.req[owner_r] && !bus.lock[owner_r]) begin
                    // Owner abandoned the burst between commands.
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Select the granted requester's masks and compute the new flag value.
    always_comb begin
        sel_set_s  = '0;
        sel_rst_s  = '0;
        q_next_s   = q_r;
        err_next_s = err_r;
        for (int i = 0; i < NREQ; i++) begin
            sel_set_s = sel_set_s | (bus.set_mask[i*NFLAG +: NFLAG] & {NFLAG{gnt_s[i]}});
            sel_rst_s = sel_rst_s | (bus.rst_mask[i*NFLAG +: NFLAG] & {NFLAG{gnt_s[i]}});
        end
`ifdef SR_FLAG_ILLEGAL_CHECK_EN
        if (gnt_valid_s && |(sel_set_s & sel_rst_s)) begin
            // Whole command is dropped; only the sticky error records it.
            err_next_s = 1'b1;
        end else if (gnt_valid_s) begin
            for (int k = 0; k < NFLAG; k++) begin
                q_next_s[k] = sr_next(q_r[k], sel_set_s[k], sel_rst_s[k]);
            end
        end else begin
            q_next_s = q_r;
        end
`else
        err_next_s = 1'b0;
        if (gnt_valid_s) begin
            for (int k = 0; k < NFLAG; k++) begin
                q_next_s[k] = sr_next(q_r[k], sel_set_s[k], sel_rst_s[k]);
            end
        end else begin
            q_next_s = q_r;
        end
`endif
    end

    // State, pointer, owner, flag bank, ack pulse and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            owner_r <= '0;
            ack_r   <= '0;
            q_r     <= '0;
            qbar_r  <= '1;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
            owner_r <= owner_next_s;
            ack_r   <= gnt_s;
            q_r     <= q_next_s;
            qbar_r  <= ~q_next_s;
            err_r   <= err_next_s;
        end
    end

    assign bus.ack    = ack_r;
    assign bus.q      = q_r;
    assign bus.qbar   = qbar_r;
    assign bus.owner  = owner_r;
    assign bus.locked = (state_r == ST_LOCKED);
    assign bus.err    = err_r;

endmodule

// File: tb/tb_sr_flag_bank_ctrl.sv
// Testbench for sr_flag_bank_ctrl (NREQ=4, NFLAG=8). Expected results are
// queued when a command is presented and compared when the matching ack is seen.
module tb_sr_flag_bank_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sr_flag_bank_ctrl_if #(.NREQ(4), .NFLAG(8)) bus ();

    sr_flag_bank_ctrl #(.NREQ(4), .NFLAG(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] q;
        int         lat;
        logic       locked;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

`ifdef SR_FLAG_ILLEGAL_CHECK_EN
    localparam bit ILL_CHK = 1'b1;
`else
    localparam bit ILL_CHK = 1'b0;
`endif

    function automatic void push(logic [3:0] a, logic [7:0] q, int lat, logic lk, logic er);
        exp_t e;
        e.ack = a; e.q = q; e.lat = lat; e.locked = lk; e.err = er;
        sb_q.push_back(e);
    endfunction

    task automatic drive_cmd(int i, logic r, logic l, logic [7:0] s, logic [7:0] c);
        bus.req[i]            = r;
        bus.lock[i]           = l;
        bus.set_mask[i*8 +: 8] = s;
        bus.rst_mask[i*8 +: 8] = c;
    endtask

    task automatic clear_inputs();
        bus.req      = 4'b0000;
        bus.lock     = 4'b0000;
        bus.set_mask = 32'h0;
        bus.rst_mask = 32'h0;
    endtask

    // Waits (bounded) for the next negedge showing a nonzero ack; lat=-1 on timeout.
    task automatic wait_ack(output logic [3:0] a, output int lat);
        bit found;
        found = 1'b0;
        a     = 4'b0000;
        lat   = 0;
        for (int n = 1; n <= 10 && !found; n++) begin
            @(negedge clk);
            if (bus.ack !== 4'b0000) begin
                found = 1'b1;
                a     = bus.ack;
                lat   = n;
            end
        end
        if (!found) lat = -1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (bus.q !== 8'h00 || bus.qbar !== 8'hFF || bus.ack !== 4'b0000 ||
            bus.owner !== 2'd0 || bus.locked !== 1'b0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: q=%h qbar=%h ack=%b owner=%0d locked=%b err=%b, want 00 ff 0000 0 0 0",
                     bus.q, bus.qbar, bus.ack, bus.owner, bus.locked, bus.err);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] a; int lat; exp_t e;
        apply_reset();
        drive_cmd(0, 1'b1, 1'b0, 8'h0F, 8'h00);
        push(4'b0001, 8'h0F, 1, 1'b0, 1'b0);
        push(4'b0001, 8'h0C, 2, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_ack(a, lat);
            e = sb_q.pop_front();
            vectors++;
            if (a !== e.ack || bus.q !== e.q || bus.qbar !== ~e.q || lat != e.lat ||
                bus.locked !== e.locked || bus.err !== e.err) begin
                miscompares++;
                $display("FAIL single[%0d]: ack=%b q=%h qbar=%h lat=%0d, want ack=%b q=%h lat=%0d",
                         k, a, bus.q, bus.qbar, lat, e.ack, e.q, e.lat);
            end
            if (k == 0) drive_cmd(0, 1'b1, 1'b0, 8'h00, 8'h03);
            else        drive_cmd(0, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        @(negedge clk);
        vectors++;
        if (bus.ack !== 4'b0000 || bus.q !== 8'h0C) begin
            miscompares++;
            $display("FAIL single_pulse: ack=%b q=%h, want ack=0000 q=0c", bus.ack, bus.q);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] a; int lat; exp_t e; logic [7:0] acc;
        apply_reset();
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(i, 1'b1, 1'b0, 8'(1 << i), 8'h00);
            acc = acc | 8'(1 << i);
            push(4'(1 << i), acc, 1, 1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            wait_ack(a, lat);
            e = sb_q.pop_front();
            vectors++;
            if (a !== e.ack || bus.q !== e.q || bus.qbar !== ~e.q || lat != e.lat ||
                bus.locked !== e.locked || bus.err !== e.err) begin
                miscompares++;
                $display("FAIL rr[%0d]: ack=%b q=%h lat=%0d, want ack=%b q=%h lat=%0d",
                         k, a, bus.q, lat, e.ack, e.q, e.lat);
            end
            for (int i = 0; i < 4; i++) if (a[i]) drive_cmd(i, 1'b0, 1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic test_lock_burst();
        logic [3:0] a; int lat; exp_t e;
        apply_reset();
        drive_cmd(2, 1'b1, 1'b1, 8'h01, 8'h00);
        push(4'b0100, 8'h01, 1, 1'b1, 1'b0);
        push(4'b0100, 8'h03, 2, 1'b1, 1'b0);
        push(4'b0100, 8'h07, 2, 1'b0, 1'b0);
        push(4'b0001, 8'h87, 1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(a, lat);
            e = sb_q.pop_front();
            vectors++;
            if (a !== e.ack || bus.q !== e.q || bus.qbar !== ~e.q || lat != e.lat ||
                bus.locked !== e.locked || bus.err !== e.err || (k < 2 && bus.owner !== 2'd2)) begin
                miscompares++;
                $display("FAIL lock[%0d]: ack=%b q=%h lat=%0d locked=%b owner=%0d, want ack=%b q=%h lat=%0d locked=%b owner=2",
                         k, a, bus.q, lat, bus.locked, bus.owner, e.ack, e.q, e.lat, e.locked);
            end
            case (k)
                0: begin
                    drive_cmd(2, 1'b1, 1'b1, 8'h02, 8'h00);
                    drive_cmd(0, 1'b1, 1'b0, 8'h80, 8'h00);
                end
                1: drive_cmd(2, 1'b1, 1'b0, 8'h04, 8'h00);
                2: drive_cmd(2, 1'b0, 1'b0, 8'h00, 8'h00);
                default: drive_cmd(0, 1'b0, 1'b0, 8'h00, 8'h00);
            endcase
        end
    endtask

    task automatic test_set_clear();
        logic [3:0] a; int lat; exp_t e;
        apply_reset();
        drive_cmd(0, 1'b1, 1'b0, 8'hFF, 8'h00);
        drive_cmd(1, 1'b1, 1'b0, 8'h00, 8'h0F);
        push(4'b0001, 8'hFF, 1, 1'b0, 1'b0);
        push(4'b0010, 8'hF0, 1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_ack(a, lat);
            e = sb_q.pop_front();
            vectors++;
            if (a !== e.ack || bus.q !== e.q || bus.qbar !== ~e.q || lat != e.lat ||
                bus.locked !== e.locked || bus.err !== e.err) begin
                miscompares++;
                $display("FAIL setclr[%0d]: ack=%b q=%h lat=%0d, want ack=%b q=%h lat=%0d",
                         k, a, bus.q, lat, e.ack, e.q, e.lat);
            end
            for (int i = 0; i < 4; i++) if (a[i]) drive_cmd(i, 1'b0, 1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] a; int lat; exp_t e;
        apply_reset();
        drive_cmd(0, 1'b1, 1'b0, 8'h10, 8'h00);
        push(4'b0001, 8'h10, 1, 1'b0, 1'b0);
        push(4'b0001, ILL_CHK ? 8'h10 : 8'h13, 2, 1'b0, ILL_CHK);
        push(4'b0001, ILL_CHK ? 8'h30 : 8'h33, 2, 1'b0, ILL_CHK);
        push(4'b0001, ILL_CHK ? 8'h30 : 8'h32, 2, 1'b0, ILL_CHK);
        for (int k = 0; k < 4; k++) begin
            wait_ack(a, lat);
            e = sb_q.pop_front();
            vectors++;
            if (a !== e.ack || bus.q !== e.q || bus.qbar !== ~e.q || lat != e.lat ||
                bus.locked !== e.locked || bus.err !== e.err) begin
                miscompares++;
                $display("FAIL illegal[%0d]: ack=%b q=%h err=%b lat=%0d, want ack=%b q=%h err=%b lat=%0d",
                         k, a, bus.q, bus.err, lat, e.ack, e.q, e.err, e.lat);
            end
            case (k)
                0: drive_cmd(0, 1'b1, 1'b0, 8'h03, 8'h01);
                1: drive_cmd(0, 1'b1, 1'b0, 8'h20, 8'h00);
                2: drive_cmd(0, 1'b1, 1'b0, 8'h01, 8'h01);
                default: drive_cmd(0, 1'b0, 1'b0, 8'h00, 8'h00);
            endcase
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.err !== ILL_CHK) begin
            miscompares++;
            $display("FAIL illegal_sticky: err=%b, want %b", bus.err, ILL_CHK);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] a; int lat; exp_t e;
        apply_reset();
        drive_cmd(1, 1'b1, 1'b1, 8'hAA, 8'h00);
        push(4'b0010, 8'hAA, 1, 1'b1, 1'b0);
        wait_ack(a, lat);
        e = sb_q.pop_front();
        vectors++;
        if (a !== e.ack || bus.q !== e.q || lat != e.lat || bus.locked !== e.locked || bus.owner !== 2'd1) begin
            miscompares++;
            $display("FAIL midrst_pre: ack=%b q=%h lat=%0d locked=%b owner=%0d, want 0010 aa 1 1 1",
                     a, bus.q, lat, bus.locked, bus.owner);
        end
        drive_cmd(1, 1'b1, 1'b1, 8'h55, 8'h00);
        drive_cmd(3, 1'b1, 1'b0, 8'h80, 8'h00);
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.q !== 8'h00 || bus.qbar !== 8'hFF || bus.locked !== 1'b0 || bus.ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_now: q=%h qbar=%h locked=%b ack=%b, want 00 ff 0 0000",
                     bus.q, bus.qbar, bus.locked, bus.ack);
        end
        sb_q.delete();
        drive_cmd(1, 1'b1, 1'b0, 8'h01, 8'h00);
        drive_cmd(3, 1'b1, 1'b0, 8'h80, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        push(4'b0010, 8'h01, 1, 1'b0, 1'b0);
        push(4'b1000, 8'h81, 1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_ack(a, lat);
            e = sb_q.pop_front();
            vectors++;
            if (a !== e.ack || bus.q !== e.q || bus.qbar !== ~e.q || lat != e.lat ||
                bus.locked !== e.locked || bus.err !== e.err) begin
                miscompares++;
                $display("FAIL midrst_post[%0d]: ack=%b q=%h lat=%0d, want ack=%b q=%h lat=%0d",
                         k, a, bus.q, lat, e.ack, e.q, e.lat);
            end
            for (int i = 0; i < 4; i++) if (a[i]) drive_cmd(i, 1'b0, 1'b0, 8'h00, 8'h00);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_lock_burst();
        test_set_clear();
        test_illegal();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
